transmitter: RTL and testbench

Sending end of the 16-bit Request/Ack word handshake.
- Buffers words from a local producer in a small FIFO.
- Presents each word on DataOut with Request high, and waits for Ack from the far-end receiver.
- Retries on timeout, and counts delivered words in bursts of BURST.

---
 rtl/transmitter_pkg.sv | 14 +
 rtl/tx_fifo.sv | 63 ++++++
 rtl/transmitter.sv | 119 +++++++++++
 tb/tb_transmitter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transmitter_pkg.sv
// Shared definitions for the Request/Ack word link: transmitter state encoding
// and the default word width, also used by the receiving end.
package transmitter_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        REQUEST      = 2'd1,
        WAIT_RELEASE = 2'd2,
        BACKOFF      = 2'd3
    } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous DEPTH x WIDTH word FIFO with registered Full/Empty flags.
// A push while full is refused even if a pop happens on the same edge.
module tx_fifo
    import transmitter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    // Flags come from the next count so they are registered alongside it.
    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/transmitter.sv
// Sending end of the Request/Ack word link: buffers producer words, offers each
// to the receiver with timeout/retry, and pulses Done every BURST deliveries.
module transmitter
    import transmitter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 15,
    parameter int MAX_RETRY = 3,
    parameter int BURST     = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Send,
    input  logic [WIDTH-1:0] DataIn,
    output logic             Full,
    output logic             Overflow,
    output logic             Request,
    input  logic             Ack,
    output logic [WIDTH-1:0] DataOut,
    output logic             Done,
    output logic             Error,
    output tx_state_t        State
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    logic [TW-1:0]    timer;
    logic [RW-1:0]    retry;
    logic [CW-1:0]    word_cnt;
    logic [WIDTH-1:0] fifo_head;
    logic             fifo_empty;
    logic             fifo_pop;

    tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .Reset (Reset),
        .push  (Send),
        .pop   (fifo_pop),
        .din   (DataIn),
        .head  (fifo_head),
        .full  (Full),
        .empty (fifo_empty)
    );

    // Head leaves the FIFO on a successful Ack or when it runs out of retries.
    always_comb begin
        fifo_pop = 1'b0;
        case (State)
            REQUEST: fifo_pop = Ack;
            BACKOFF: fifo_pop = (retry == RW'(MAX_RETRY));
            default: fifo_pop = 1'b0;
        endcase
    end

    // Four-phase handshake: DataOut is valid and stable while Request=1; a word
    // is taken when Ack=1 is sampled with Request=1, and Request stays low
    // until Ack has returned to 0.
    always_ff @(posedge clk) begin
        if (Reset) begin
            State    <= IDLE;
            Request  <= 1'b0;
            DataOut  <= '0;
            timer    <= '0;
            retry    <= '0;
            word_cnt <= '0;
            Overflow <= 1'b0;
            Done     <= 1'b0;
            Error    <= 1'b0;
        end else begin
            Overflow <= Send && Full;
            Done     <= 1'b0;
            Error    <= 1'b0;
            case (State)
                IDLE: begin
                    if (!fifo_empty) begin
                        DataOut <= fifo_head;
                        Request <= 1'b1;
                        timer   <= '0;
                        State   <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (Ack) begin
                        Request <= 1'b0;
                        retry   <= '0;
                        if (word_cnt == CW'(BURST - 1)) begin
                            word_cnt <= '0;
                            Done     <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + CW'(1);
                        end
                        State <= WAIT_RELEASE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        Request <= 1'b0;
                        retry   <= retry + RW'(1);
                        State   <= BACKOFF;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_RELEASE: begin
                    if (!Ack) State <= IDLE;
                end
                BACKOFF: begin
                    if (retry == RW'(MAX_RETRY)) begin
                        Error <= 1'b1;
                        retry <= '0;
                    end
                    State <= IDLE;
                end
                default: State <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: directed scenarios plus randomized traffic against a
// transaction-level model of delivered words, timeouts, drops and bursts.
module tb_transmitter;
    import transmitter_pkg::*;

    localparam int WIDTH     = 16;
    localparam int TIMEOUT   = 15;
    localparam int MAX_RETRY = 3;
    localparam int BURST     = 16;

    logic             clk;
    logic             Reset;
    logic             Send;
    logic [WIDTH-1:0] DataIn;
    logic             Full;
    logic             Overflow;
    logic             Request;
    logic             Ack;
    logic [WIDTH-1:0] DataOut;
    logic             Done;
    logic             Error;
    tx_state_t        State;

    transmitter dut (
        .clk      (clk),
        .Reset    (Reset),
        .Send     (Send),
        .DataIn   (DataIn),
        .Full     (Full),
        .Overflow (Overflow),
        .Request  (Request),
        .Ack      (Ack),
        .DataOut  (DataOut),
        .Done     (Done),
        .Error    (Error),
        .State    (State)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    bit ovf_pend  = 0;
    int done_obs  = 0;
    int err_obs   = 0;
    int rx_delay  = 2;   // 0: never ack, 1..15: ack on that Request cycle, -1: random

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [WIDTH-1:0] d, input bit accept);
        @(negedge clk); #1;
        Send   = 1'b1;
        DataIn = d;
        if (accept) exp_q.push_back(d);
        else        ovf_pend = 1'b1;
        @(negedge clk); #1;
        Send = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        Reset = 1'b1;
        Send  = 1'b0;
        @(negedge clk); #1;
        Reset = 1'b0;
    endtask

    task automatic wait_not_full(input int budget);
        int n = 0;
        while (Full && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("full_wait_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || Request) && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        check("drain_budget", 32'(n < budget), 32'd1);
    endtask

    // ---------------- receiver model (drives Ack) ----------------
    function automatic int pick_target();
        int r;
        if (rx_delay >= 0) return rx_delay;
        r = $urandom_range(0, 9);
        if (r < 2)  return 0;
        if (r == 2) return TIMEOUT;
        return $urandom_range(1, 5);
    endfunction

    initial begin
        int st = 0;
        int cnt = 0;
        int target = 0;
        int hold = 0;
        logic req;
        logic rst;
        Ack = 1'b0;
        forever begin
            @(negedge clk);
            req = Request;
            rst = Reset;
            #1;
            if (rst) begin
                Ack = 1'b0;
                st  = 0;
            end else begin
                case (st)
                    0: if (req) begin
                        cnt    = 1;
                        target = pick_target();
                        if (target == 1) begin Ack = 1'b1; st = 2; end
                        else st = 1;
                    end
                    1: if (!req) st = 0;
                       else begin
                           cnt++;
                           if (cnt == target) begin Ack = 1'b1; st = 2; end
                       end
                    2: if (!req) begin
                        hold = $urandom_range(0, 2);
                        if (hold == 0) begin Ack = 1'b0; st = 0; end
                        else st = 3;
                    end
                    default: begin
                        hold--;
                        if (hold == 0) begin Ack = 1'b0; st = 0; end
                    end
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    logic prev_req = 1'b0;
    logic prev_ack = 1'b0;
    int   hold_cnt = 0;
    int   attempts = 0;
    int   delivered = 0;
    bit   err_due = 0;

    always @(negedge clk) begin
        bit exp_done;
        bit exp_err;
        if (Reset) begin
            check("rst_request",  32'(Request),  32'd0);
            check("rst_dataout",  32'(DataOut),  32'd0);
            check("rst_full",     32'(Full),     32'd0);
            check("rst_overflow", 32'(Overflow), 32'd0);
            check("rst_done",     32'(Done),     32'd0);
            check("rst_error",    32'(Error),    32'd0);
            exp_q.delete();
            ovf_pend  = 0;
            hold_cnt  = 0;
            attempts  = 0;
            delivered = 0;
            err_due   = 0;
            prev_req  = 1'b0;
            prev_ack  = 1'b0;
        end else begin
            check("overflow", 32'(Overflow), 32'(ovf_pend));
            ovf_pend = 0;
            exp_done = 0;
            exp_err  = err_due;
            err_due  = 0;
            if (Request && !prev_req) begin
                check("release_before_request", 32'(prev_ack), 32'd0);
                if (exp_q.size() == 0) check("spurious_request", 32'(Request), 32'd0);
                else                   check("dataout_present", 32'(DataOut), 32'(exp_q[0]));
                hold_cnt = 1;
            end else if (Request && prev_req) begin
                if (exp_q.size() != 0) check("dataout_stable", 32'(DataOut), 32'(exp_q[0]));
                hold_cnt++;
            end else if (!Request && prev_req) begin
                if (Ack) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    attempts = 0;
                    delivered++;
                    if (delivered % BURST == 0) exp_done = 1;
                end else begin
                    check("timeout_length", 32'(hold_cnt), 32'(TIMEOUT));
                    attempts++;
                    if (attempts == MAX_RETRY) begin
                        err_due = 1;
                        attempts = 0;
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                    end
                end
            end
            check("done_pulse",  32'(Done),  32'(exp_done));
            check("error_pulse", 32'(Error), 32'(exp_err));
            if (Done)  done_obs++;
            if (Error) err_obs++;
            prev_req = Request;
            prev_ack = Ack;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        int e0;
        Reset  = 1'b1;
        Send   = 1'b0;
        DataIn = '0;
        repeat (2) @(negedge clk);
        #1 Reset = 1'b0;

        // Single word, ack two cycles into the request.
        rx_delay = 2;
        send_word(16'hA5A5, 1'b1);
        check("latency_low", 32'(Request), 32'd0);
        @(negedge clk); #1;
        check("latency_high", 32'(Request), 32'd1);
        check("first_word", 32'(DataOut), 32'hA5A5);
        wait_idle(100);

        // Fill with no acks, then overflow on the fifth push.
        do_reset();
        rx_delay = 0;
        for (int i = 0; i < 4; i++) begin
            send_word(16'h1000 + 16'(i), 1'b1);
            check("fill_full", 32'(Full), 32'(i == 3));
        end
        send_word(16'hDEAD, 1'b0);
        check("overflow_full_kept", 32'(Full), 32'd1);
        rx_delay = 1;
        wait_idle(300);
        check("after_fill_full", 32'(Full), 32'd0);

        // Word never acknowledged: three timeouts then a drop.
        do_reset();
        rx_delay = 0;
        e0 = err_obs;
        send_word(16'h1234, 1'b1);
        repeat (70) @(negedge clk);
        #1;
        check("drop_error_count", 32'(err_obs - e0), 32'd1);
        check("drop_request_low", 32'(Request), 32'd0);
        check("drop_fifo_empty",  32'(Full),    32'd0);

        // Full burst: one Done pulse, no errors.
        do_reset();
        rx_delay = 1;
        d0 = done_obs;
        e0 = err_obs;
        for (int i = 0; i < BURST; i++) begin
            wait_not_full(200);
            send_word(16'($urandom), 1'b1);
        end
        wait_idle(500);
        check("burst_done_once", 32'(done_obs - d0), 32'd1);
        check("burst_no_error",  32'(err_obs - e0),  32'd0);

        // Ack on the last cycle before timeout counts as delivery.
        do_reset();
        rx_delay = TIMEOUT;
        e0 = err_obs;
        send_word(16'hBEEF, 1'b1);
        wait_idle(100);
        send_word(16'hCAFE, 1'b1);
        wait_idle(100);
        check("boundary_no_error", 32'(err_obs - e0), 32'd0);

        // Reset in the middle of a transfer with words buffered.
        do_reset();
        rx_delay = 0;
        for (int i = 0; i < 3; i++) send_word(16'h2000 + 16'(i), 1'b1);
        check("mid_request_high", 32'(Request), 32'd1);
        d0 = done_obs;
        e0 = err_obs;
        do_reset();
        repeat (20) @(negedge clk);
        #1;
        check("post_reset_request", 32'(Request), 32'd0);
        check("post_reset_full",    32'(Full),    32'd0);
        check("post_reset_pulses",  32'(done_obs - d0 + err_obs - e0), 32'd0);

        // Randomized traffic with a random receiver.
        do_reset();
        rx_delay = -1;
        for (int i = 0; i < 600; i++) begin
            if (!Full && $urandom_range(0, 2) == 0) send_word(16'($urandom), 1'b1);
            else begin
                @(negedge clk); #1;
            end
        end
        wait_idle(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
